// File: rtl/sort_pkg.sv
// Shared types and constants for the 12-input sort network and its frame controller.
// PAD is all-ones so unused slots always sort to the top of the frame.
package sort_pkg;

  localparam int N     = 12;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  typedef logic [W-1:0] data_t;

  localparam data_t PAD = '1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sort_12_frame_ctrl.sv
// Frame controller around the combinational 12-input sort network: collects up to N words,
// captures the sorted result for one cycle, then streams the first len words out in ascending order.
module sort_12_frame_ctrl #(
  parameter int N     = sort_pkg::N,
  parameter int W     = sort_pkg::W,
  parameter int CNT_W = sort_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [N*W-1:0] net_data,
  input  logic [N*W-1:0] net_sort,
  output logic           busy
);

  import sort_pkg::*;

  localparam logic [W-1:0]     PAD_W     = {W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] idx_nxt_s;
  logic [CNT_W-1:0] len_r;
  logic [W-1:0]     buf_r [N];
  logic [W-1:0]     res_r [N];
  logic [W-1:0]     sorted_s [N];

  logic             accept_s;
  logic             close_s;
  logic             done_s;

  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic [W-1:0]     out_data_r;
  logic             busy_r;
  logic             out_last_nxt_s;
  logic [W-1:0]     out_data_nxt_s;

  // Network inputs are driven straight from the frame buffer; outputs unpacked per slot.
  for (genvar g = 0; g < N; g++) begin : g_slot
    assign net_data[g*W +: W] = buf_r[g];
    assign sorted_s[g]        = net_sort[g*W +: W];
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    accept_s    = 1'b0;
    close_s     = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      FILL: begin
        accept_s = in_valid && in_ready_r;
        if (accept_s && (in_last || (cnt_r == LAST_SLOT))) begin
          close_s     = 1'b1;
          state_nxt_s = SORT;
        end else begin
          state_nxt_s = FILL;
        end
      end
      SORT: begin
        state_nxt_s = DRAIN;
        idx_nxt_s   = '0;
      end
      DRAIN: begin
        if (out_valid_r && out_ready) begin
          if (idx_r == (len_r - ONE)) begin
            done_s      = 1'b1;
            state_nxt_s = FILL;
            idx_nxt_s   = '0;
          end else begin
            idx_nxt_s   = idx_r + ONE;
          end
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = FILL;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // Output word for the next cycle; in the SORT->DRAIN step res is not yet loaded, so tap the network.
  always_comb begin
    out_last_nxt_s = 1'b0;
    out_data_nxt_s = '0;
    if (state_nxt_s == DRAIN) begin
      out_last_nxt_s = (idx_nxt_s == (len_r - ONE));
      if (state_r == SORT) begin
        out_data_nxt_s = sorted_s[0];
      end else begin
        out_data_nxt_s = res_r[idx_nxt_s];
      end
    end else begin
      out_last_nxt_s = 1'b0;
      out_data_nxt_s = '0;
    end
  end

  // State, counters and frame length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
      cnt_r   <= '0;
      idx_r   <= '0;
      len_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (done_s) begin
        cnt_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_r + ONE;
      end
      if (close_s) begin
        len_r <= cnt_r + ONE;
      end
    end
  end

  // Frame buffer: write accepted words, pad the tail on close, reload PAD when a frame has drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        buf_r[i] <= PAD_W;
      end
    end else if (done_s) begin
      for (int i = 0; i < N; i++) begin
        buf_r[i] <= PAD_W;
      end
    end else if (accept_s) begin
      for (int i = 0; i < N; i++) begin
        if (CNT_W'(i) == cnt_r) begin
          buf_r[i] <= in_data;
        end else if (close_s && (CNT_W'(i) > cnt_r)) begin
          buf_r[i] <= PAD_W;
        end
      end
    end
  end

  // Single capture of the network result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        res_r[i] <= '0;
      end
    end else if (state_r == SORT) begin
      for (int i = 0; i < N; i++) begin
        res_r[i] <= sorted_s[i];
      end
    end
  end

  // Registered interface outputs; in_ready and busy depend only on the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == FILL);
      out_valid_r <= (state_nxt_s == DRAIN);
      out_last_r  <= out_last_nxt_s;
      out_data_r  <= out_data_nxt_s;
      busy_r      <= (state_nxt_s != FILL);
    end
  end

endmodule

// File: tb/tb_sort_12_frame_ctrl.sv
// Self-checking bench for sort_12_frame_ctrl: directed table of frames, hand-written corner
// sequences and randomized frames checked against a sort-the-frame reference model.
module tb_sort_12_frame_ctrl;

  localparam int NN = 12;
  localparam int WW = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [WW-1:0]   in_data;
  logic            in_last;
  logic            in_ready;
  logic            out_valid;
  logic [WW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [NN*WW-1:0] net_data;
  logic [NN*WW-1:0] net_sort;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  sort_12_frame_ctrl #(.N(NN), .W(WW), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .net_data (net_data),
    .net_sort (net_sort),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the combinational sort network.
  function automatic logic [NN*WW-1:0] sort_model(input logic [NN*WW-1:0] d);
    logic [WW-1:0] q[$];
    logic [NN*WW-1:0] r;
    for (int i = 0; i < NN; i++) q.push_back(d[i*WW +: WW]);
    q.sort();
    r = '0;
    for (int i = 0; i < NN; i++) r[i*WW +: WW] = q[i];
    return r;
  endfunction

  assign net_sort = sort_model(net_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w[$], input bit use_last, input int gap_pct);
    int guard;
    int g;
    for (int i = 0; i < w.size(); i++) begin
      @(negedge clk);
      g = 0;
      while (g < 3 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
        g++;
      end
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = use_last && (i == w.size() - 1);
      guard = 0;
      while (!in_ready && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL push_timeout word=%0d actual in_ready=0 required=1", i);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic pull(input int n, input int stall_at, input int stall_pct, input bit check_end,
                      output logic [31:0] got[$], output bit lst[$]);
    logic [31:0] hd;
    logic        hl;
    int guard;
    int s;
    got = {};
    lst = {};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      guard = 0;
      while (!out_valid && guard < 400) begin
        @(negedge clk);
        guard++;
      end
      if (!out_valid) begin
        checks++;
        failures++;
        $display("FAIL pull_timeout word=%0d actual out_valid=0 required=1", i);
        return;
      end
      if (i == stall_at) s = 3;
      else if (stall_pct > 0 && $urandom_range(99) < stall_pct) s = $urandom_range(1, 3);
      else s = 0;
      hd = out_data;
      hl = out_last;
      repeat (s) begin
        @(negedge clk);
        chk("hold_data", out_data, hd);
        chk("hold_last", {31'd0, out_last}, {31'd0, hl});
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      got.push_back(out_data);
      lst.push_back(out_last);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
    if (check_end) begin
      @(negedge clk);
      chk("drain_end_valid", {31'd0, out_valid}, 32'd0);
      chk("drain_end_in_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  // Compare an output sequence against the ascending order of the submitted words.
  task automatic cmp_frame(input string tag, input logic [31:0] sent[$], input int keep,
                           input logic [31:0] got[$], input bit lst[$]);
    logic [31:0] e[$];
    e = sent;
    e.sort();
    chk({tag, "_count"}, got.size(), keep);
    for (int i = 0; i < keep && i < got.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got[i], e[i]);
      chk($sformatf("%s_last%0d", tag, i), {31'd0, lst[i]}, {31'd0, (i == e.size() - 1)});
    end
  endtask

  typedef struct {
    int          n;
    logic [31:0] w   [12];
    bit          use_last;
    int          stall_at;
    logic [31:0] exp [12];
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [31:0] q[$];
    logic [31:0] q2[$];
    logic [31:0] got[$];
    bit          lst[$];
    logic [31:0] follow[$];
    logic [NN*WW-1:0] all_pad;

    all_pad = '1;
    follow  = '{32'd7, 32'd3};

    tbl[0].n = 12; tbl[0].use_last = 1'b0; tbl[0].stall_at = -1;
    for (int i = 0; i < 12; i++) begin
      tbl[0].w[i]   = 32'(11 - i);
      tbl[0].exp[i] = 32'(i);
    end
    tbl[1].n = 5; tbl[1].use_last = 1'b1; tbl[1].stall_at = -1;
    tbl[1].w   = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[1].exp = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[2].n = 8; tbl[2].use_last = 1'b1; tbl[2].stall_at = 3;
    tbl[2].w   = '{32'd50, 32'd20, 32'd80, 32'd10, 32'd70, 32'd30, 32'd60, 32'd40, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[2].exp = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[3].n = 2; tbl[3].use_last = 1'b1; tbl[3].stall_at = -1;
    tbl[3].w   = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[3].exp = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    checks++;
    if (net_data !== all_pad) begin
      failures++;
      $display("FAIL rst_net_data actual=%0h expected=all-ones", net_data);
    end
    rst_n = 1'b1;

    // Directed table, each frame followed by a stalled 2-word frame held on the input.
    for (int k = 0; k < 4; k++) begin
      q = {};
      for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].w[i]);
      push(q, tbl[k].use_last, 0);
      @(negedge clk);
      chk($sformatf("t%0d_sort_valid", k), {31'd0, out_valid}, 32'd0);
      chk($sformatf("t%0d_sort_busy", k), {31'd0, busy}, 32'd1);
      chk($sformatf("t%0d_sort_in_ready", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("t%0d_first_valid", k), {31'd0, out_valid}, 32'd1);
      fork
        pull(tbl[k].n, tbl[k].stall_at, 0, 1'b1, got, lst);
        push(follow, 1'b1, 0);
      join
      chk($sformatf("t%0d_count", k), got.size(), tbl[k].n);
      for (int i = 0; i < tbl[k].n && i < got.size(); i++) begin
        chk($sformatf("t%0d_data%0d", k, i), got[i], tbl[k].exp[i]);
        chk($sformatf("t%0d_last%0d", k, i), {31'd0, lst[i]}, {31'd0, (i == tbl[k].n - 1)});
      end
      pull(2, -1, 0, 1'b1, got, lst);
      cmp_frame($sformatf("t%0d_follow", k), follow, 2, got, lst);
    end

    // Back-to-back: full frame immediately followed by a single word.
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(32'd100 + 32'($urandom_range(0, 900)));
    q2 = '{32'd42};
    fork
      begin
        push(q, 1'b0, 0);
        push(q2, 1'b1, 0);
      end
      begin
        pull(12, -1, 0, 1'b0, got, lst);
        cmp_frame("b2b_first", q, 12, got, lst);
        pull(1, -1, 0, 1'b1, got, lst);
        cmp_frame("b2b_second", q2, 1, got, lst);
      end
    join

    // Reset in the middle of a drain, then a fresh 3-word frame.
    q = '{32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10};
    push(q, 1'b1, 0);
    pull(4, -1, 0, 1'b0, got, lst);
    cmp_frame("pre_rst", q, 4, got, lst);
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    checks++;
    if (net_data !== all_pad) begin
      failures++;
      $display("FAIL mid_rst_net_data actual=%0h expected=all-ones", net_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q = '{32'd9, 32'd2, 32'd5};
    push(q, 1'b1, 0);
    pull(3, -1, 0, 1'b1, got, lst);
    cmp_frame("post_rst", q, 3, got, lst);

    // Randomized frames with input gaps and output back-pressure.
    for (int f = 0; f < 40; f++) begin
      int  n;
      bit  ul;
      int  mode;
      n  = $urandom_range(1, 12);
      ul = (n < 12) ? 1'b1 : 1'($urandom_range(0, 1));
      q  = {};
      for (int i = 0; i < n; i++) begin
        mode = $urandom_range(0, 3);
        if (mode == 0) q.push_back(32'hFFFF_FFFF);
        else if (mode == 1) q.push_back(32'($urandom_range(0, 7)));
        else q.push_back($urandom);
      end
      fork
        push(q, ul, 30);
        pull(n, -1, 30, 1'b1, got, lst);
      join
      cmp_frame($sformatf("rnd%0d", f), q, n, got, lst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sort_12_frame_ctrl.md
# sort_12_frame_ctrl

Sequencing controller for the 12-input, 8-stage combinational sort network. It collects a frame of up to 12 words from a valid/ready input stream and presents them to the network. It captures the sorted result in one register stage, then streams the words out in ascending order over a valid/ready output. It sits between a streaming producer/consumer pair and the purely combinational sorter, and owns all buffering, padding and flow control around it.

## Interface
Parameters:
- N, 12, frame size; must match the network width
- W, 32, data width; must match data_t
- CNT_W, 4, width of the slot counter, equal to $clog2(N+1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low (already decided)
- in_valid  in  1  producer has a word
- in_data  in  W  input word, unsigned
- in_last  in  1  marks the final word of a short frame
- in_ready  out  1  controller accepts a word this cycle
- out_valid  out  1  sorted word available
- out_data  out  W  sorted word, ascending order
- out_last  out  1  marks the final valid word of the frame
- out_ready  in  1  consumer accepts
- net_data  out  N*W  to network inputs; slot i is bits [i*W +: W]
- net_sort  in  N*W  from network outputs; slot i is the i-th smallest value
- busy  out  1  high in SORT or DRAIN

## Operation
State machine states: FILL, SORT, DRAIN. Reset state is FILL.

FILL:
- in_ready = 1.
- A word is accepted when in_valid && in_ready. It is written to buf[cnt], and cnt increments.
- The frame closes when the accepted word has in_last = 1 or is the N-th word (cnt == N-1). On close, go to SORT.
- On close, store len = number of accepted words (1..N). Load every unwritten slot with PAD = all-ones so padding sorts to the top.
- in_valid with in_last and no prior words gives a 1-word frame. A frame of exactly N words closes with or without in_last. A word after an auto-closed frame starts a new frame.

SORT (exactly 1 cycle):
- in_ready = 0.
- res <= net_sort. idx <= 0.
- Go to DRAIN.

DRAIN:
- out_valid = 1, out_data = res[idx], out_last = (idx == len-1).
- On out_valid && out_ready: if out_last, go to FILL, clear cnt and reload buf to PAD; else idx++.
- in_ready = 0 throughout; input words are never dropped, the producer is stalled.

Common rules:
- net_data is driven continuously from buf. The network has no clock; only the SORT capture samples it.
- Only the first len words are emitted. A genuine 0xFFFFFFFF input ties with PAD and is still emitted correctly, because equal values are indistinguishable.
- Comparison is unsigned.

## Timing
Reset values:
- in_ready = 1; out_valid = 0, out_last = 0, out_data = 0; busy = 0.
- cnt = 0, idx = 0, len = 0.
- buf = PAD; res = 0.

Latency and throughput:
- Closing word accepted at edge t. SORT is active in cycle t+1. The first out_valid appears in cycle t+2.
- Throughput is one frame per (len + len + 1) cycles minimum. Frames do not overlap.

Handshake rules:
- While out_valid && !out_ready, out_data and out_last hold stable.
- in_ready depends only on state, with no combinational path from out_ready.

Reset mid-operation:
- rst_n low in any state immediately forces the reset values.
- A partial frame or an undrained result is discarded.

## Structure
- Shared package sort_pkg: data_t (logic [31:0]), N = 12, CNT_W, PAD = '1, and the state enum {FILL, SORT, DRAIN}.
- Single module, no sub-module. The sort network is instantiated by the parent and connected through net_data/net_sort, so the controller can be verified against a behavioural sort model.

## Test plan
- Full frame: 12 words 11,10,…,0 with no in_last. Out is 0..11, out_last on the word 11, first out_valid 2 cycles after the 12th accept.
- Short frame: 9,3,7,1,5 with in_last on 5. Out is 1,3,5,7,9 only, out_last on 9, then in_ready = 1.
- Back-pressure: out_ready low for 3 cycles mid-drain. out_data/out_last hold; in_ready stays 0 while in_valid is held high; no word is lost.
- Pad tie: frame 0xFFFFFFFF,2 with in_last. Out is 2 then 0xFFFFFFFF, with out_last on the second word.
- Back-to-back: 12-word frame immediately followed by a 1-word frame (value 42). Second output is exactly 42 with out_last; no stale values from the first frame leak into the second.
- Reset mid-DRAIN after 4 outputs. Outputs return to reset values asynchronously; a new 3-word frame then sorts correctly.
